stereo_gain_scheduler: RTL and testbench

- Sequences one shared signed 16x16 multiplier across both stereo channels and two gain stages: modulation (tremolo LFO coefficient), then master volume.
- Sits between the codec sample source and the audio output path.
- Uses valid/ready handshakes on input and output so the sine/LFO generator and downstream effects can stall it.

---
 rtl/stereo_gain_scheduler_pkg.sv | 34 +++
 rtl/stereo_gain_scheduler_shared_mult.sv | 30 +++
 rtl/stereo_gain_scheduler.sv | 171 +++++++++++++++++
 tb/tb_stereo_gain_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stereo_gain_scheduler_pkg.sv
// Shared types, Q1.15 constants and the shift/saturate helper used by the
// stereo gain scheduler and its shared multiplier.
package stereo_gain_scheduler_pkg;

  localparam int unsigned      Q_SHIFT = 15;
  localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAT_MIN = 16'sh8000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ML1   = 3'd1,
    ST_MR1   = 3'd2,
    ST_ML2   = 3'd3,
    ST_MR2   = 3'd4,
    ST_DRAIN = 3'd5,
    ST_OUT   = 3'd6
  } state_e;

  // Floor-shift a Q2.30 product back to Q1.15; only -1.0 * -1.0 can overflow.
  function automatic logic signed [15:0] q15_shift_sat(input logic signed [31:0] prod);
    logic signed [31:0] shifted;
    logic signed [15:0] res;
    shifted = prod >>> Q_SHIFT;
    if (shifted > 32'sd32767) begin
      res = SAT_MAX;
    end else if (shifted < -32'sd32768) begin
      res = SAT_MIN;
    end else begin
      res = shifted[15:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/stereo_gain_scheduler_shared_mult.sv
// Registered signed Q1.15 multiply with floor shift and saturation.
// One operand pair per cycle, result one cycle later.
module shared_mult
  import stereo_gain_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  output logic signed [DATA_WIDTH-1:0] p_o
);

  logic signed [2*DATA_WIDTH-1:0] prod_s;
  logic signed [DATA_WIDTH-1:0]   p_q;

  assign prod_s = a_i * b_i;
  assign p_o    = p_q;

  // Product register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= 16'sd0;
    end else begin
      p_q <= q15_shift_sat(prod_s);
    end
  end

endmodule

// File: rtl/stereo_gain_scheduler.sv
// Time-multiplexes one Q1.15 multiplier over left/right samples for an
// optional tremolo stage followed by master volume, with valid/ready on both sides.
module stereo_gain_scheduler
  import stereo_gain_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] audio_left_in,
  input  logic [DATA_WIDTH-1:0] audio_right_in,
  input  logic [DATA_WIDTH-1:0] mod_coef,
  input  logic [DATA_WIDTH-1:0] vol_coef,
  input  logic                  mod_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] audio_left_out,
  output logic [DATA_WIDTH-1:0] audio_right_out
);

  state_e state_q, state_d;

  logic signed [DATA_WIDTH-1:0] l_q, r_q, mod_q, vol_q;
  logic signed [DATA_WIDTH-1:0] l1_q, r1_q, res_l_q;
  logic signed [DATA_WIDTH-1:0] out_l_q, out_r_q;
  logic                         mod_en_q, out_valid_q;

  logic signed [DATA_WIDTH-1:0] mult_a_s, mult_b_s, mult_p_s;
  logic accept_s, out_xfer_s;
  logic cap_l1_s, cap_r1_s, cap_res_l_s, load_out_s;

  assign in_ready        = (state_q == ST_IDLE);
  assign accept_s        = in_valid && in_ready;
  assign out_xfer_s      = (state_q == ST_OUT) && out_ready;
  assign out_valid       = out_valid_q;
  assign audio_left_out  = out_l_q;
  assign audio_right_out = out_r_q;

  shared_mult #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mult (
    .clk  (clk),
    .rst_n(rst_n),
    .a_i  (mult_a_s),
    .b_i  (mult_b_s),
    .p_o  (mult_p_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = mod_en ? ST_ML1 : ST_ML2;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ML1:   state_d = ST_MR1;
      ST_MR1:   state_d = ST_ML2;
      ST_ML2:   state_d = ST_MR2;
      ST_MR2:   state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_OUT;
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OUT;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Operand steering and capture strobes; each product lands one state later
  always_comb begin
    mult_a_s    = 16'sd0;
    mult_b_s    = 16'sd0;
    cap_l1_s    = 1'b0;
    cap_r1_s    = 1'b0;
    cap_res_l_s = 1'b0;
    load_out_s  = 1'b0;
    case (state_q)
      ST_ML1: begin
        mult_a_s = l_q;
        mult_b_s = mod_q;
      end
      ST_MR1: begin
        mult_a_s = r_q;
        mult_b_s = mod_q;
        cap_l1_s = 1'b1;
      end
      ST_ML2: begin
        mult_a_s = l1_q;
        mult_b_s = vol_q;
        cap_r1_s = mod_en_q;
      end
      ST_MR2: begin
        mult_a_s    = r1_q;
        mult_b_s    = vol_q;
        cap_res_l_s = 1'b1;
      end
      ST_DRAIN: begin
        load_out_s = 1'b1;
      end
      default: begin
        mult_a_s = 16'sd0;
        mult_b_s = 16'sd0;
      end
    endcase
  end

  // Datapath: input latch, intermediate results and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_q         <= 16'sd0;
      r_q         <= 16'sd0;
      mod_q       <= 16'sd0;
      vol_q       <= 16'sd0;
      mod_en_q    <= 1'b0;
      l1_q        <= 16'sd0;
      r1_q        <= 16'sd0;
      res_l_q     <= 16'sd0;
      out_l_q     <= 16'sd0;
      out_r_q     <= 16'sd0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept_s) begin
        l_q      <= audio_left_in;
        r_q      <= audio_right_in;
        mod_q    <= mod_coef;
        vol_q    <= vol_coef;
        mod_en_q <= mod_en;
        // Bypass feeds the raw samples straight into the volume stage
        if (!mod_en) begin
          l1_q <= audio_left_in;
          r1_q <= audio_right_in;
        end
      end
      if (cap_l1_s) begin
        l1_q <= mult_p_s;
      end
      if (cap_r1_s) begin
        r1_q <= mult_p_s;
      end
      if (cap_res_l_s) begin
        res_l_q <= mult_p_s;
      end
      if (load_out_s) begin
        out_l_q     <= res_l_q;
        out_r_q     <= mult_p_s;
        out_valid_q <= 1'b1;
      end else if (out_xfer_s) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stereo_gain_scheduler.sv
// Directed bench for stereo_gain_scheduler: a transaction-level model checked
// every cycle, plus literal expectations for the documented vectors.
module tb_stereo_gain_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] audio_left_in = 16'h0000;
  logic [15:0] audio_right_in = 16'h0000;
  logic [15:0] mod_coef = 16'h0000;
  logic [15:0] vol_coef = 16'h0000;
  logic        mod_en = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] audio_left_out;
  logic [15:0] audio_right_out;

  int tests = 0;
  int fails = 0;

  stereo_gain_scheduler #(.DATA_WIDTH(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .audio_left_in  (audio_left_in),
    .audio_right_in (audio_right_in),
    .mod_coef       (mod_coef),
    .vol_coef       (vol_coef),
    .mod_en         (mod_en),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .audio_left_out (audio_left_out),
    .audio_right_out(audio_right_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Q1.15 gain as plain integer arithmetic: floor of a*b/2^15, clamped.
  function automatic logic [15:0] gain(input logic [15:0] a, input logic [15:0] b);
    longint p;
    longint r;
    logic [15:0] res;
    p = longint'($signed(a)) * longint'($signed(b));
    r = p >>> 15;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    res = r[15:0];
    return res;
  endfunction

  // Transaction model: one pair in flight, result visible after fixed latency
  bit          busy = 1'b0;
  bit          outv = 1'b0;
  int          cyc = 0;
  int          due = 0;
  int          acc_cnt = 0;
  int          acc_cyc = 0;
  int          xfer_cnt = 0;
  logic [15:0] pend_l = 16'h0000, pend_r = 16'h0000;
  logic [15:0] exp_l = 16'h0000, exp_r = 16'h0000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  = 1'b0;
      outv  = 1'b0;
      exp_l = 16'h0000;
      exp_r = 16'h0000;
    end else begin
      logic [15:0] s1_l, s1_r;
      cyc++;
      if (!busy) begin
        if (in_valid) begin
          busy    = 1'b1;
          acc_cnt++;
          acc_cyc = cyc;
          due     = cyc + (mod_en ? 5 : 3);
          s1_l    = mod_en ? gain(audio_left_in, mod_coef) : audio_left_in;
          s1_r    = mod_en ? gain(audio_right_in, mod_coef) : audio_right_in;
          pend_l  = gain(s1_l, vol_coef);
          pend_r  = gain(s1_r, vol_coef);
        end
      end else if (outv) begin
        if (out_ready) begin
          outv = 1'b0;
          busy = 1'b0;
          xfer_cnt++;
        end
      end else if (cyc == due) begin
        outv  = 1'b1;
        exp_l = pend_l;
        exp_r = pend_r;
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", {31'd0, in_ready}, {31'd0, !busy});
    chk("out_valid", {31'd0, out_valid}, {31'd0, outv});
    chk("left_out", {16'd0, audio_left_out}, {16'd0, exp_l});
    chk("right_out", {16'd0, audio_right_out}, {16'd0, exp_r});
  end

  task automatic drive(input logic [15:0] l, input logic [15:0] r,
                       input logic [15:0] m, input logic [15:0] v, input logic en);
    audio_left_in  = l;
    audio_right_in = r;
    mod_coef       = m;
    vol_coef       = v;
    mod_en         = en;
  endtask

  task automatic send(input bit keep);
    int a;
    a = acc_cnt;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && acc_cnt == a; i++) begin
      @(posedge clk);
      #1;
    end
    if (acc_cnt == a) chk("accept_timeout", 32'd0, 32'd1);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
    if (!out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
    lat = cyc - acc_cyc;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  logic [15:0] b2b_l [8] = '{16'h2000, 16'h8000, 16'h7FFF, 16'h1234,
                             16'hFFFF, 16'h0001, 16'hC000, 16'h5A5A};
  logic [15:0] b2b_r [8] = '{16'hE000, 16'h8000, 16'h0100, 16'hEDCC,
                             16'h4000, 16'h8001, 16'h3FFF, 16'hA5A5};
  logic [15:0] b2b_m [8] = '{16'h4000, 16'h8000, 16'h7FFF, 16'hC000,
                             16'h2000, 16'h8001, 16'h6000, 16'hF000};
  logic [15:0] b2b_v [8] = '{16'h7FFF, 16'h7FFF, 16'h4000, 16'h8000,
                             16'h0003, 16'h7FFF, 16'hE000, 16'h1111};

  initial begin
    int lat;
    int x0;
    int acc_at [8];

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_left", {16'd0, audio_left_out}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    settle();

    // Basic tremolo + volume
    drive(16'h2000, 16'hE000, 16'h4000, 16'h7FFF, 1'b1);
    send(1'b0);
    wait_valid(lat);
    chk("basic_latency", lat, 32'd5);
    chk("basic_left", {16'd0, audio_left_out}, 32'h0000_0FFF);
    chk("basic_right", {16'd0, audio_right_out}, 32'h0000_F000);
    settle();

    // Modulation stage saturates on -1.0 * -1.0
    drive(16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 1'b1);
    send(1'b0);
    wait_valid(lat);
    chk("sat_left", {16'd0, audio_left_out}, 32'h0000_7FFE);
    chk("sat_right", {16'd0, audio_right_out}, 32'h0000_7FFE);
    settle();

    // Bypass: volume only, three-cycle latency
    drive(16'h1234, 16'h0001, 16'h0000, 16'h8000, 1'b0);
    send(1'b0);
    wait_valid(lat);
    chk("bypass_latency", lat, 32'd3);
    chk("bypass_left", {16'd0, audio_left_out}, 32'h0000_EDCC);
    chk("bypass_right", {16'd0, audio_right_out}, 32'h0000_FFFF);
    settle();

    // Backpressure with input noise while the result is held
    out_ready = 1'b0;
    drive(16'h4000, 16'hC000, 16'h7FFF, 16'h4000, 1'b1);
    send(1'b0);
    wait_valid(lat);
    x0 = xfer_cnt;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'($urandom_range(0, 1));
      drive(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end
    in_valid  = 1'b0;
    @(negedge clk);
    chk("bp_hold_left", {16'd0, audio_left_out}, 32'h0000_1FFF);
    chk("bp_hold_right", {16'd0, audio_right_out}, 32'h0000_E000);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_one_transfer", xfer_cnt - x0, 32'd1);
    @(negedge clk);
    chk("bp_in_ready_after", {31'd0, in_ready}, 32'd1);
    settle();

    // Reset asserted while MR1 is active
    drive(16'h2000, 16'hE000, 16'h4000, 16'h7FFF, 1'b1);
    send(1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_left", {16'd0, audio_left_out}, 32'd0);
    chk("rst_mid_right", {16'd0, audio_right_out}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    send(1'b0);
    wait_valid(lat);
    chk("post_rst_left", {16'd0, audio_left_out}, 32'h0000_0FFF);
    chk("post_rst_right", {16'd0, audio_right_out}, 32'h0000_F000);
    settle();

    // Back-to-back pairs with both handshakes held high
    x0 = xfer_cnt;
    for (int i = 0; i < 8; i++) begin
      drive(b2b_l[i], b2b_r[i], b2b_m[i], b2b_v[i], 1'b1);
      send(1'b1);
      acc_at[i] = acc_cyc;
    end
    in_valid = 1'b0;
    for (int i = 1; i < 8; i++) chk("b2b_spacing", acc_at[i] - acc_at[i-1], 32'd7);
    for (int i = 0; i < 40 && xfer_cnt - x0 < 8; i++) @(posedge clk);
    chk("b2b_count", xfer_cnt - x0, 32'd8);
    settle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
